itch_msg_framer: RTL and testbench

ITCH_MSG_FRAMER -- requirements
Module: itch_msg_framer

---
 rtl/itch_msg_framer.sv | 138 +++++++++++++
 tb/tb_itch_msg_framer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/itch_msg_framer.sv
// ITCH message framer: strips the 16-bit big-endian length prefix from a
// byte stream and emits message bytes with sof/eof/index framing.
// Ports: S_AXIS_ACLK/S_AXIS_ARESETN clock and async active-low reset;
//   in_byte/in_valid input stream (no backpressure);
//   out_byte/out_valid/out_sof/out_eof/out_byte_idx framed byte stream;
//   out_msg_type/out_msg_len per-message info held until next sof;
//   msg_count completed messages; err_len zero-length pulse;
//   len_mismatch type/length table pulse.
// Optional macro ITCH_LEN_CHECK_EN enables the type/length check table.
module itch_msg_framer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 S_AXIS_ACLK,
    input  logic                 S_AXIS_ARESETN,
    input  logic [7:0]           in_byte,
    input  logic                 in_valid,
    output logic [7:0]           out_byte,
    output logic                 out_valid,
    output logic                 out_sof,
    output logic                 out_eof,
    output logic [7:0]           out_msg_type,
    output logic [15:0]          out_byte_idx,
    output logic [15:0]          out_msg_len,
    output logic [CNT_WIDTH-1:0] msg_count,
    output logic                 err_len,
    output logic                 len_mismatch
);

    typedef enum logic [1:0] {
        LEN_HI,
        LEN_LO,
        BODY
    } state_t;

    state_t      state;
    logic [7:0]  len_hi;
    logic [15:0] length;
    logic [15:0] remaining;

    logic [15:0] len_now;
    logic        first;
    logic        last;

    assign len_now = {len_hi, in_byte};
    // remaining starts at length, so equality marks the type byte
    assign first   = (remaining == length);
    assign last    = (remaining == 16'd1);

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state        <= LEN_HI;
            len_hi       <= 8'd0;
            length       <= 16'd0;
            remaining    <= 16'd0;
            out_byte     <= 8'd0;
            out_valid    <= 1'b0;
            out_sof      <= 1'b0;
            out_eof      <= 1'b0;
            out_msg_type <= 8'd0;
            out_byte_idx <= 16'd0;
            out_msg_len  <= 16'd0;
            msg_count    <= '0;
            err_len      <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_sof   <= 1'b0;
            out_eof   <= 1'b0;
            err_len   <= 1'b0;
            if (in_valid) begin
                case (state)
                    LEN_HI: begin
                        len_hi <= in_byte;
                        state  <= LEN_LO;
                    end
                    LEN_LO: begin
                        if (len_now == 16'd0) begin
                            err_len <= 1'b1;
                            state   <= LEN_HI;
                        end else begin
                            length    <= len_now;
                            remaining <= len_now;
                            state     <= BODY;
                        end
                    end
                    BODY: begin
                        out_valid    <= 1'b1;
                        out_byte     <= in_byte;
                        out_byte_idx <= length - remaining;
                        out_sof      <= first;
                        out_eof      <= last;
                        remaining    <= remaining - 16'd1;
                        if (first) begin
                            out_msg_type <= in_byte;
                            out_msg_len  <= length;
                        end
                        if (last) begin
                            msg_count <= msg_count
                                       + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                            state     <= LEN_HI;
                        end
                    end
                    default: state <= LEN_HI;
                endcase
            end
        end
    end

`ifdef ITCH_LEN_CHECK_EN
    // expected length per known type; 0 means "not checked"
    function automatic logic [15:0] table_len(input logic [7:0] t);
        case (t)
            8'h53:   return 16'd12;
            8'h41:   return 16'd36;
            8'h44:   return 16'd19;
            8'h45:   return 16'd31;
            8'h58:   return 16'd23;
            8'h55:   return 16'd35;
            8'h50:   return 16'd44;
            default: return 16'd0;
        endcase
    endfunction

    logic [15:0] tlen;
    assign tlen = table_len(in_byte);

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            len_mismatch <= 1'b0;
        end else begin
            len_mismatch <= in_valid && (state == BODY) && first
                         && (tlen != 16'd0) && (tlen != length);
        end
    end
`else
    assign len_mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_itch_msg_framer.sv
// Testbench for itch_msg_framer: table-driven framing vectors plus
// hand-written reset-mid-message sequence; second instance checks wrap.
module tb_itch_msg_framer;

`ifdef ITCH_LEN_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_byte;
    logic        in_valid;
    logic [7:0]  out_byte;
    logic        out_valid;
    logic        out_sof;
    logic        out_eof;
    logic [7:0]  out_msg_type;
    logic [15:0] out_byte_idx;
    logic [15:0] out_msg_len;
    logic [31:0] msg_count;
    logic        err_len;
    logic        len_mismatch;

    logic [7:0]  b2;
    logic        v2, sof2, eof2, err2, mm2;
    logic [7:0]  typ2;
    logic [15:0] idx2, len2;
    logic [1:0]  cnt2;

    itch_msg_framer #(.CNT_WIDTH(32)) dut (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
        .in_byte(in_byte), .in_valid(in_valid),
        .out_byte(out_byte), .out_valid(out_valid),
        .out_sof(out_sof), .out_eof(out_eof),
        .out_msg_type(out_msg_type), .out_byte_idx(out_byte_idx),
        .out_msg_len(out_msg_len), .msg_count(msg_count),
        .err_len(err_len), .len_mismatch(len_mismatch)
    );

    itch_msg_framer #(.CNT_WIDTH(2)) dut2 (
        .S_AXIS_ACLK(clk), .S_AXIS_ARESETN(rst_n),
        .in_byte(in_byte), .in_valid(in_valid),
        .out_byte(b2), .out_valid(v2),
        .out_sof(sof2), .out_eof(eof2),
        .out_msg_type(typ2), .out_byte_idx(idx2),
        .out_msg_len(len2), .msg_count(cnt2),
        .err_len(err2), .len_mismatch(mm2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [7:0]  b;
        logic        ev;
        logic        es;
        logic        ee;
        logic [15:0] ei;
        logic        eerr;
        logic        emm;
        int unsigned ecnt;
    } vec_t;

    vec_t        tbl[$];
    int unsigned mcnt;
    int          total;
    int          bad;

    task automatic push(input logic v, input logic [7:0] b,
                        input logic ev, input logic es, input logic ee,
                        input int ei, input logic eerr, input logic emm);
        vec_t r;
        r.v = v; r.b = b; r.ev = ev; r.es = es; r.ee = ee;
        r.ei = 16'(ei); r.eerr = eerr; r.emm = emm; r.ecnt = mcnt;
        tbl.push_back(r);
    endtask

    task automatic gen_msg(input logic [7:0] t, input int len,
                           input int gap_at, input int gap_n,
                           input logic mm);
        logic [7:0] b;
        push(1'b1, 8'(len >> 8), 0, 0, 0, 0, 0, 0);
        push(1'b1, 8'(len), 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < len; i++) begin
            b = (i == 0) ? t : 8'(i * 37 + 5);
            if (i == len - 1) mcnt++;
            push(1'b1, b, 1, i == 0, i == len - 1, i, 0, (i == 0) && mm);
            if (i == gap_at)
                for (int g = 0; g < gap_n; g++)
                    push(1'b0, 8'hEE, 0, 0, 0, 0, 0, 0);
        end
    endtask

    task automatic step(input logic v, input logic [7:0] b);
        @(negedge clk);
        in_valid = v;
        in_byte  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, got, exp);
        end
    endtask

    initial begin
        logic ok;
        total = 0;
        bad   = 0;
        mcnt  = 0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        in_byte  = 8'h00;

        gen_msg(8'h53, 12, -1, 0, 1'b0);
        gen_msg(8'h41, 1, -1, 0, CHK);
        push(1'b1, 8'h00, 0, 0, 0, 0, 0, 0);
        push(1'b1, 8'h00, 0, 0, 0, 0, 1, 0);
        gen_msg(8'h44, 19, -1, 0, 1'b0);
        gen_msg(8'h53, 12, 4, 3, 1'b0);
        gen_msg(8'h44, 20, -1, 0, CHK);
        gen_msg(8'h5A, 3, -1, 0, 1'b0);
        push(1'b0, 8'h00, 0, 0, 0, 0, 0, 0);

        #3;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_count", msg_count, 0);
        chk("rst_type", 32'(out_msg_type), 0);
        chk("rst_idx", 32'(out_byte_idx), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            step(tbl[k].v, tbl[k].b);
            ok = (out_valid === tbl[k].ev) && (out_sof === tbl[k].es)
              && (out_eof === tbl[k].ee) && (err_len === tbl[k].eerr)
              && (len_mismatch === tbl[k].emm)
              && (msg_count === tbl[k].ecnt)
              && (cnt2 === 2'(tbl[k].ecnt))
              && (!tbl[k].ev || ((out_byte === tbl[k].b)
                                 && (out_byte_idx === tbl[k].ei)));
            total++;
            if (!ok) begin
                bad++;
                $display("FAIL vec%0d: got v%b s%b e%b b%h i%0d er%b mm%b c%0d c2=%0d want v%b s%b e%b b%h i%0d er%b mm%b c%0d",
                         k, out_valid, out_sof, out_eof, out_byte,
                         out_byte_idx, err_len, len_mismatch, msg_count,
                         cnt2, tbl[k].ev, tbl[k].es, tbl[k].ee, tbl[k].b,
                         tbl[k].ei, tbl[k].eerr, tbl[k].emm, tbl[k].ecnt);
            end
        end

        chk("held_type", 32'(out_msg_type), 32'h5A);
        chk("held_len", 32'(out_msg_len), 3);

        step(1'b1, 8'h00);
        step(1'b1, 8'h24);
        for (int i = 0; i <= 6; i++)
            step(1'b1, (i == 0) ? 8'h41 : 8'(i));
        chk("mid_idx", 32'(out_byte_idx), 6);
        chk("mid_len", 32'(out_msg_len), 36);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 0);
        chk("arst_idx", 32'(out_byte_idx), 0);
        chk("arst_len", 32'(out_msg_len), 0);
        chk("arst_count", msg_count, 0);
        repeat (2) @(posedge clk);
        #1;
        chk("arst_hold", 32'({out_valid, out_eof, out_sof}), 0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b1;

        step(1'b1, 8'h00);
        chk("post_hi", 32'(out_valid), 0);
        step(1'b1, 8'h0C);
        step(1'b1, 8'h53);
        chk("post_sof", 32'({out_valid, out_sof, out_eof}), 32'b110);
        chk("post_byte", 32'(out_byte), 32'h53);
        chk("post_type", 32'(out_msg_type), 32'h53);
        chk("post_len", 32'(out_msg_len), 12);
        for (int i = 1; i < 12; i++) step(1'b1, 8'(i + 100));
        chk("post_eof", 32'({out_valid, out_eof}), 32'b11);
        chk("post_eidx", 32'(out_byte_idx), 11);
        chk("post_count", msg_count, 1);
        step(1'b0, 8'h00);
        chk("post_idle", 32'(out_valid), 0);
        chk("post_cnt2", 32'(cnt2), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
